game_flow_controller: RTL
=========================

// Module: game_flow_controller
// PURPOSE
//  Top-level game sequencer for whack-a-mole. Owns the one-hot game state and current level fed to the
//  mole generator, consumes its 2-bit hit result, keeps score/miss counts, and decides level-up, win and loss.
//  Sits between the button front-end (debounced start/abort) and the mole generator + display.
// PARAMETERS
//  HITS_PER_LEVEL  8    successful hits needed to advance one level (>=1)
//  MAX_LEVEL       9    highest level; clearing it -> win (<=9, level drives 5000*(9-level) math downstream)
//  MAX_MISSES      3    misses that end the game (1..7)
//  TIMEOUT_CYCLES  3000000  game time limit in clk cycles (used only with GAME_TIMER_EN)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous active-low reset
//  start_req   in   1   debounced start button level; rising edge is the event
//  abort_req   in   1   debounced abort level; sampled while high
//  level_sel   in   4   starting level, latched on start edge
//  hit_result  in   2   from mole generator: 2'b10 hit, 2'b01 miss, 2'b00 none
//  state       out  4   one-hot: 0001 before, 0010 in-game, 0100 lost, 1000 win
//  level       out  4   current level 0..MAX_LEVEL
//  score       out  8   total hits this game, saturates at 255
//  misses      out  3   misses this game
//  time_left   out  22  remaining cycles / 2^10 (GAME_TIMER_EN), else 0
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (ports clk, rst).
//  Reset: state=0001, level=0, score=0, misses=0, internal hit count=0, start edge reg=0, time_left=0.
//  Start edge: start_d<=start_req each cycle; start_evt = start_req & ~start_d (one cycle).
//  All outputs registered; every transition takes effect the cycle after the triggering sample.
//  BEFORE: start_evt -> IN; level<=min(level_sel,MAX_LEVEL); score,misses,hit_cnt<=0; timer loaded.
//  IN, priority abort > timeout > hit_result:
//   abort_req=1 -> BEFORE, counters cleared.
//   hit 2'b10: score+=1 (sat 255); if hit_cnt==HITS_PER_LEVEL-1: hit_cnt<=0 and
//     level==MAX_LEVEL -> WIN (level held) else level+=1; otherwise hit_cnt+=1.
//   miss 2'b01: misses+=1; if misses==MAX_MISSES-1 -> LOST.
//   2'b11 illegal: ignored, no counter change. 2'b00: hold. start_evt ignored in IN.
//  LOST/WIN: level/score/misses frozen for display; start_evt -> BEFORE (clears counters);
//   abort_req -> BEFORE. hit_result ignored.
//  Level boundary: hit on last level hit-count clears level and wins in same cycle; no level MAX_LEVEL+1.
//  Illegal state encoding (not one-hot) -> BEFORE next cycle.
//  Reset mid-game: immediate asynchronous return to BEFORE values, no pending events kept.
// CONFIGURATION
//  GAME_TIMER_EN defined: 22+10-bit down-counter loaded with TIMEOUT_CYCLES on entering IN, decrements in IN,
//   frozen in LOST/WIN; reaching 0 in IN -> LOST next cycle; time_left = counter[31:10].
//  Not defined: no timer logic, time_left tied 0, game ends only via misses/win/abort.
// STRUCTURE
//  Package game_pkg: state encodings (ST_BEFORE/ST_IN/ST_LOST/ST_WIN), hit codes (HIT_OK/HIT_MISS/HIT_NONE),
//   shared with the mole generator and display blocks.
//  Sub-module game_timer (load, enable, expired, remaining), instantiated only under GAME_TIMER_EN.
//  Main FSM, edge detector and counters live in this module.
// TESTING
//  1 reset low mid-IN with score=5 -> state=0001, level=0, score=0, misses=0 immediately.
//  2 level_sel=3, start rise, 8x hit_result=10 (1-cycle pulses) -> level=4, score=8, state=0010.
//  3 level_sel=12, start -> level=9; 8 hits -> state=1000, level=9, score=8; further hits ignored.
//  4 start, 3 misses interleaved with 1 hit -> state=0100 after 3rd miss, misses=3, score=1.
//  5 start held high 100 cycles in BEFORE -> single start event; in LOST start rise -> 0001, counters 0.
//  6 GAME_TIMER_EN, TIMEOUT_CYCLES=1000: start, no hits -> state=0100 at cycle 1001; abort same cycle wins -> 0001.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game blocks.
// Holds the one-hot game state encodings and the hit-result codes used by the
// flow controller, the mole generator and the display logic.
package game_pkg;

   // One-hot game state as seen on the controller's state output.
   typedef enum logic [3:0] {
      ST_BEFORE = 4'b0001,
      ST_IN     = 4'b0010,
      ST_LOST   = 4'b0100,
      ST_WIN    = 4'b1000
   } game_state_t;

   // Result codes reported by the mole generator once per cycle.
   localparam logic [1:0] HIT_OK   = 2'b10;
   localparam logic [1:0] HIT_MISS = 2'b01;
   localparam logic [1:0] HIT_NONE = 2'b00;

   // Starting levels above the top level are pulled down to the top level.
   function automatic logic [3:0] clampLevel(input logic [3:0] sel, input logic [3:0] maxLevel);
      return (sel > maxLevel) ? maxLevel : sel;
   endfunction

endpackage

// File: rtl/game_timer.sv
// Game time limit counter.
// A 32-bit down-counter: load restarts it at TIMEOUT_CYCLES, enable lets it
// count down and it stops at zero. expired is high while the count is zero.
// remaining reports the count in units of 1024 cycles for the display.
// Only instantiated when GAME_TIMER_EN is defined.
module game_timer #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        enable,
   output logic        expired,
   output logic [21:0] remaining
);

   logic [31:0] r_count;

   // Load wins over counting; the count parks at zero so expiry stays visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= 32'd0;
      end else if (load) begin
         r_count <= TIMEOUT_CYCLES;
      end else if (enable && (r_count != 32'd0)) begin
         r_count <= r_count - 32'd1;
      end
   end

   assign expired   = (r_count == 32'd0);
   assign remaining = r_count[31:10];

endmodule

// File: rtl/game_flow_controller.sv
// Top-level whack-a-mole game sequencer.
// Owns the one-hot game state and the current level handed to the mole
// generator, consumes the generator's hit result, keeps score and miss counts
// and decides level-up, win and loss. All outputs are registered.
// Optional feature macro: GAME_TIMER_EN adds a game time limit (game_timer);
// without it time_left is tied to zero and games end only by misses, win or abort.
module game_flow_controller
   import game_pkg::*;
#(
   parameter int          HITS_PER_LEVEL = 8,
   parameter int          MAX_LEVEL      = 9,
   parameter int          MAX_MISSES     = 3,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_req,
   input  logic        abort_req,
   input  logic [3:0]  level_sel,
   input  logic [1:0]  hit_result,
   output logic [3:0]  state,
   output logic [3:0]  level,
   output logic [7:0]  score,
   output logic [2:0]  misses,
   output logic [21:0] time_left
);

   localparam logic [7:0] LP_HIT_LAST  = 8'(HITS_PER_LEVEL - 1);
   localparam logic [3:0] LP_MAX_LEVEL = 4'(MAX_LEVEL);
   localparam logic [2:0] LP_MISS_LAST = 3'(MAX_MISSES - 1);

   game_state_t r_state;
   game_state_t w_stateNxt;

   logic        r_startD;
   logic        w_startEvt;

   logic [3:0]  r_level;
   logic [7:0]  r_score;
   logic [2:0]  r_misses;
   logic [7:0]  r_hitCnt;

   logic [3:0]  w_levelNxt;
   logic [7:0]  w_scoreNxt;
   logic [2:0]  w_missesNxt;
   logic [7:0]  w_hitCntNxt;

   logic        w_timerExpired;
   logic [21:0] w_timeLeft;

   assign w_startEvt = start_req & ~r_startD;

`ifdef GAME_TIMER_EN
   logic w_timerLoad;
   logic w_timerEnable;

   assign w_timerLoad   = (r_state == ST_BEFORE) && w_startEvt;
   assign w_timerEnable = (r_state == ST_IN);

   game_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gameTimer (
      .clk       (clk),
      .rst       (rst),
      .load      (w_timerLoad),
      .enable    (w_timerEnable),
      .expired   (w_timerExpired),
      .remaining (w_timeLeft)
   );
`else
   logic w_unusedTimeout;

   assign w_unusedTimeout = ^TIMEOUT_CYCLES;
   assign w_timerExpired  = 1'b0;
   assign w_timeLeft      = 22'd0;
`endif

   // Remember last cycle's start level so a held button produces one event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_startD <= 1'b0;
      end else begin
         r_startD <= start_req;
      end
   end

   // Game state register; reset drops straight back to the idle screen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_BEFORE;
      end else begin
         r_state <= w_stateNxt;
      end
   end

   // Score, miss and level bookkeeping registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_level  <= 4'd0;
         r_score  <= 8'd0;
         r_misses <= 3'd0;
         r_hitCnt <= 8'd0;
      end else begin
         r_level  <= w_levelNxt;
         r_score  <= w_scoreNxt;
         r_misses <= w_missesNxt;
         r_hitCnt <= w_hitCntNxt;
      end
   end

   // Next state and counters; in play abort beats timeout beats the hit result.
   always_comb begin
      w_stateNxt  = r_state;
      w_levelNxt  = r_level;
      w_scoreNxt  = r_score;
      w_missesNxt = r_misses;
      w_hitCntNxt = r_hitCnt;

      case (r_state)
         ST_BEFORE: begin
            if (w_startEvt) begin
               w_stateNxt  = ST_IN;
               w_levelNxt  = clampLevel(level_sel, LP_MAX_LEVEL);
               w_scoreNxt  = 8'd0;
               w_missesNxt = 3'd0;
               w_hitCntNxt = 8'd0;
            end
         end

         ST_IN: begin
            if (abort_req) begin
               w_stateNxt  = ST_BEFORE;
               w_levelNxt  = 4'd0;
               w_scoreNxt  = 8'd0;
               w_missesNxt = 3'd0;
               w_hitCntNxt = 8'd0;
            end else if (w_timerExpired) begin
               w_stateNxt = ST_LOST;
            end else begin
               case (hit_result)
                  HIT_OK: begin
                     w_scoreNxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                     if (r_hitCnt == LP_HIT_LAST) begin
                        w_hitCntNxt = 8'd0;
                        if (r_level == LP_MAX_LEVEL) begin
                           w_stateNxt = ST_WIN;
                        end else begin
                           w_levelNxt = r_level + 4'd1;
                        end
                     end else begin
                        w_hitCntNxt = r_hitCnt + 8'd1;
                     end
                  end
                  HIT_MISS: begin
                     w_missesNxt = r_misses + 3'd1;
                     if (r_misses == LP_MISS_LAST) begin
                        w_stateNxt = ST_LOST;
                     end
                  end
                  HIT_NONE: begin
                     w_stateNxt = r_state;
                  end
                  default: begin
                     w_stateNxt = r_state;
                  end
               endcase
            end
         end

         ST_LOST, ST_WIN: begin
            if (w_startEvt || abort_req) begin
               w_stateNxt  = ST_BEFORE;
               w_levelNxt  = 4'd0;
               w_scoreNxt  = 8'd0;
               w_missesNxt = 3'd0;
               w_hitCntNxt = 8'd0;
            end
         end

         default: begin
            w_stateNxt  = ST_BEFORE;
            w_levelNxt  = 4'd0;
            w_scoreNxt  = 8'd0;
            w_missesNxt = 3'd0;
            w_hitCntNxt = 8'd0;
         end
      endcase
   end

   assign state     = r_state;
   assign level     = r_level;
   assign score     = r_score;
   assign misses    = r_misses;
   assign time_left = w_timeLeft;

endmodule
